gate_seq_ctrl: RTL and testbench

GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

---
 rtl/gate_seq_ctrl_if.sv | 25 ++
 rtl/gate_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_gate_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_seq_ctrl_if.sv
// Handshake and result bundle between a gate sequencer and whatever drives it.
// The master side supplies the run controls and the gate response; the slave is the sequencer.
interface gate_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic [3:0] tt;
  logic       dut_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    output start, abort, tt, dut_out,
    input  a, b, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    input  start, abort, tt, dut_out,
    output a, b, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/gate_seq_ctrl.sv
// Steps a two-input gate through {a,b}=00,01,10,11, lets each vector settle,
// and checks the gate output against a latched truth table.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | vector idx driven on a,b, settle counter running
// CHECK  | one cycle: compare dut_out with tt[idx], record mismatch
// DONE   | one cycle: done pulse, pass valid
module gate_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  gate_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] tt_q;
  logic [3:0] cnt;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_q;
  logic [3:0] mask_q;
  logic       mismatch;
  logic [2:0] err_upd;

  // err_upd includes the current CHECK result so pass can use it in the same edge
  always_comb begin
    mismatch = (bus.dut_out != tt_q[idx]);
    err_upd  = err_q;
    if (mismatch && (err_q != 3'd4)) err_upd = err_q + 3'd1;
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      tt_q   <= 4'd0;
      cnt    <= 4'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 3'd0;
      mask_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tt_q   <= bus.tt;
            idx    <= 2'd0;
            err_q  <= 3'd0;
            mask_q <= 4'd0;
            pass_q <= 1'b0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            idx    <= 2'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          // abort wins over recording this vector's result
          if (bus.abort) begin
            idx    <= 2'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            err_q <= err_upd;
            if (mismatch) mask_q <= mask_q | (4'b0001 << idx);
            if (idx == 2'd3) begin
              done_q <= 1'b1;
              pass_q <= (err_upd == 3'd0);
              state  <= DONE;
            end else begin
              idx        <= idx + 2'd1;
              {a_q, b_q} <= idx + 2'd1;
              cnt        <= CNT_LOAD;
              state      <= SETTLE;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: one instance with SETTLE_CYCLES=1, one with 3,
// each driving a behavioural gate model selected per test.
module tb_gate_seq_ctrl;
  localparam int M_AND = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_OR = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mode1;
  int   mode3;

  gate_seq_ctrl_if bus1 ();
  gate_seq_ctrl_if bus3 ();

  gate_seq_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate_seq_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic gate_fn(int m, logic a, logic b);
    case (m)
      M_AND:    return a & b;
      M_STUCK0: return 1'b0;
      default:  return a | b;
    endcase
  endfunction

  always_comb bus1.dut_out = gate_fn(mode1, bus1.a, bus1.b);
  always_comb bus3.dut_out = gate_fn(mode3, bus3.a, bus3.b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++;
    if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_mask} !== 12'd0) begin
      failures++;
      $display("FAIL reset_s1 outputs got=%b exp=0", {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_mask});
    end
    checks++;
    if ({bus3.a, bus3.b, bus3.busy, bus3.done, bus3.pass, bus3.err_count, bus3.fail_mask} !== 12'd0) begin
      failures++;
      $display("FAIL reset_s3 outputs got=%b exp=0", {bus3.a, bus3.b, bus3.busy, bus3.done, bus3.pass, bus3.err_count, bus3.fail_mask});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full run on the SETTLE_CYCLES=1 instance; start is sampled at edge 0 and
  // each loop iteration observes the cycle following edge k.
  task automatic test_run1(string name, int m, logic [3:0] ttv, logic [2:0] e_err,
                           logic [3:0] e_mask, logic e_pass, bit tt_flip);
    int dcount;
    dcount = 0;
    @(negedge clk);
    mode1 = m;
    bus1.tt = ttv;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      if (tt_flip && k == 3) bus1.tt = ~ttv;
      if (bus1.done === 1'b1) dcount++;
      if (k < 8) begin
        checks++;
        if ({bus1.a, bus1.b} !== 2'(k / 2)) begin
          failures++;
          $display("FAIL %s ab k=%0d got=%b exp=%b", name, k, {bus1.a, bus1.b}, 2'(k / 2));
        end
      end
      checks++;
      if (bus1.busy !== (k <= 8)) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, bus1.busy, (k <= 8));
      end
      checks++;
      if (bus1.done !== (k == 8)) begin
        failures++;
        $display("FAIL %s done k=%0d got=%b exp=%b", name, k, bus1.done, (k == 8));
      end
      if (k >= 8) begin
        checks++;
        if ({bus1.pass, bus1.err_count, bus1.fail_mask} !== {e_pass, e_err, e_mask}) begin
          failures++;
          $display("FAIL %s result k=%0d got pass=%b err=%0d mask=%b exp pass=%b err=%0d mask=%b",
                   name, k, bus1.pass, bus1.err_count, bus1.fail_mask, e_pass, e_err, e_mask);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.pass, bus1.err_count, bus1.fail_mask, bus1.busy, bus1.done} !== {e_pass, e_err, e_mask, 2'b00}) begin
      failures++;
      $display("FAIL %s idle_hold got pass=%b err=%0d mask=%b busy=%b done=%b",
               name, bus1.pass, bus1.err_count, bus1.fail_mask, bus1.busy, bus1.done);
    end
    checks++;
    if (dcount != 1) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, dcount);
    end
  endtask

  task automatic test_settle3();
    int dcount;
    dcount = 0;
    @(negedge clk);
    mode3 = M_AND;
    bus3.tt = 4'b1000;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) bus3.start = 1'b1;
      if (k == 5) bus3.start = 1'b0;
      if (bus3.done === 1'b1) dcount++;
      if (k < 16) begin
        checks++;
        if ({bus3.a, bus3.b} !== 2'(k / 4)) begin
          failures++;
          $display("FAIL s3 ab k=%0d got=%b exp=%b", k, {bus3.a, bus3.b}, 2'(k / 4));
        end
      end
      checks++;
      if (bus3.done !== (k == 16)) begin
        failures++;
        $display("FAIL s3 done k=%0d got=%b exp=%b", k, bus3.done, (k == 16));
      end
      checks++;
      if (bus3.busy !== (k <= 16)) begin
        failures++;
        $display("FAIL s3 busy k=%0d got=%b exp=%b", k, bus3.busy, (k <= 16));
      end
    end
    checks++;
    if ({bus3.pass, bus3.err_count, bus3.fail_mask} !== {1'b1, 3'd0, 4'd0}) begin
      failures++;
      $display("FAIL s3 result got pass=%b err=%0d mask=%b exp pass=1 err=0 mask=0000",
               bus3.pass, bus3.err_count, bus3.fail_mask);
    end
    checks++;
    if (dcount != 1) begin
      failures++;
      $display("FAIL s3 done_pulses got=%0d exp=1", dcount);
    end
  endtask

  task automatic test_abort();
    int dcount;
    dcount = 0;
    @(negedge clk);
    mode1 = M_OR;
    bus1.tt = 4'b1000;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    // now in CHECK of vector 01 with the OR model mismatching; abort must win
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    checks++;
    if ({bus1.busy, bus1.a, bus1.b, bus1.pass, bus1.done} !== 5'b0) begin
      failures++;
      $display("FAIL abort outputs got busy=%b ab=%b%b pass=%b done=%b exp all 0",
               bus1.busy, bus1.a, bus1.b, bus1.pass, bus1.done);
    end
    checks++;
    if ({bus1.err_count, bus1.fail_mask} !== {3'd0, 4'd0}) begin
      failures++;
      $display("FAIL abort partial got err=%0d mask=%b exp err=0 mask=0000", bus1.err_count, bus1.fail_mask);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus1.done === 1'b1 || bus1.busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      failures++;
      $display("FAIL abort stays_idle got=%0d active cycles exp=0", dcount);
    end
    test_run1("after_abort", M_AND, 4'b1000, 3'd0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    int dcount;
    dcount = 0;
    @(negedge clk);
    mode1 = M_OR;
    bus1.tt = 4'b1000;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus1.a, bus1.b, bus1.err_count, bus1.fail_mask, bus1.busy} !== {2'b10, 3'd1, 4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid pre got ab=%b%b err=%0d mask=%b busy=%b exp ab=10 err=1 mask=0010 busy=1",
               bus1.a, bus1.b, bus1.err_count, bus1.fail_mask, bus1.busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_mask} !== 12'd0) begin
      failures++;
      $display("FAIL rst_mid async got=%b exp=0",
               {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_mask});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus1.done === 1'b1 || bus1.busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      failures++;
      $display("FAIL rst_mid stays_idle got=%0d active cycles exp=0", dcount);
    end
    test_run1("after_reset", M_AND, 4'b1000, 3'd0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dcount;
    dcount = 0;
    @(negedge clk);
    mode1 = M_AND;
    bus1.tt = 4'b1000;
    bus1.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 19; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) bus1.start = 1'b0;
      if (bus1.done === 1'b1) dcount++;
      checks++;
      if (bus1.done !== (k == 8 || k == 18)) begin
        failures++;
        $display("FAIL b2b done k=%0d got=%b", k, bus1.done);
      end
      checks++;
      if (bus1.busy !== (k != 9 && k != 19)) begin
        failures++;
        $display("FAIL b2b busy k=%0d got=%b exp=%b", k, bus1.busy, (k != 9 && k != 19));
      end
    end
    checks++;
    if (dcount != 2 || bus1.pass !== 1'b1) begin
      failures++;
      $display("FAIL b2b summary got pulses=%0d pass=%b exp pulses=2 pass=1", dcount, bus1.pass);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mode1 = M_AND;
    mode3 = M_AND;
    rst_n = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus1.tt = 4'd0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
    bus3.tt = 4'd0;

    test_reset();
    test_run1("and_gate", M_AND, 4'b1000, 3'd0, 4'b0000, 1'b1, 1'b1);
    test_run1("stuck0", M_STUCK0, 4'b1000, 3'd1, 4'b1000, 1'b0, 1'b0);
    test_run1("or_gate", M_OR, 4'b1000, 3'd2, 4'b0110, 1'b0, 1'b0);
    test_run1("inverted_tt", M_AND, 4'b0111, 3'd4, 4'b1111, 1'b0, 1'b0);
    test_settle3();
    test_abort();
    test_reset_midrun();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
